// File: rtl/bram_epp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_epp_ctrl
// Purpose  : EPP host port onto one port of a block RAM. The host strobe is
//            synchronised into clk. Four targets are decoded from address
//            bits [7:6]: data port, address low, address high and ctrl/status.
//            Data-port accesses wait while the acquisition state machine owns
//            the BRAM. Auto-increment and an overflow flag are supported.
// Config   : BRAM_EPP_WRAP_EN -- when defined, the address wraps from
//            2^ADDR_W-1 to 0. When undefined, the address saturates and data
//            writes are blocked until the overflow flag is cleared.
// Revision : 1.0 - initial release
// ============================================================================
module bram_epp_ctrl #(
  parameter int ADDR_W       = 12,
  parameter int AUTO_INC_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stbData,
  input  logic              ctrlWr,
  input  logic [7:0]        busEppIn,
  input  logic [7:0]        busEppAddrIn,
  input  logic              stmBusy,
  input  logic [7:0]        busBramIn,
  output logic [7:0]        busEppOut,
  output logic              eppWait,
  output logic [ADDR_W-1:0] busBramAddr,
  output logic [7:0]        busBramOut,
  output logic              ctrlWeBram,
  output logic              enBram,
  output logic              ovfFlag
);

  // FSM encoding
  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_wait_busy = 3'd1;
  localparam logic [2:0] c_st_access    = 3'd2;
  localparam logic [2:0] c_st_read_wait = 3'd3;
  localparam logic [2:0] c_st_hold      = 3'd4;

  // Target select decode of busEppAddrIn[7:6]
  localparam logic [1:0] c_sel_data  = 2'b00;
  localparam logic [1:0] c_sel_addrl = 2'b01;
  localparam logic [1:0] c_sel_addrh = 2'b10;
  localparam logic [1:0] c_sel_ctrl  = 2'b11;

  localparam logic [ADDR_W-1:0] c_addr_max = '1;

  // Strobe synchroniser and edge detection
  logic r_stb_s1;
  logic r_stb_s2;
  logic r_stb_d;
  logic w_fall;
  logic w_rise;

  // Control state
  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [1:0]        r_sel;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic              r_auto_inc;
  logic              r_ovf;
  logic [7:0]        r_dout;

  // Datapath helpers
  logic       w_data_acc;
  logic       w_wr_block;
  logic       w_bram_go;
  logic       w_inc_en;
  logic       w_at_max;
  logic [7:0] w_reg_rd;
  logic       w_unused;

  // The low six EPP address bits carry no meaning for this block
  assign w_unused = &{1'b0, busEppAddrIn[5:0]};

  // Two-flop synchroniser plus one delay stage for strobe edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stb_s1 <= 1'b1;
      r_stb_s2 <= 1'b1;
      r_stb_d  <= 1'b1;
    end else begin
      r_stb_s1 <= stbData;
      r_stb_s2 <= r_stb_s1;
      r_stb_d  <= r_stb_s2;
    end
  end

  assign w_fall = r_stb_d & ~r_stb_s2;
  assign w_rise = ~r_stb_d & r_stb_s2;

  assign w_data_acc = (r_sel == c_sel_data);
  assign w_at_max   = (r_addr == c_addr_max);

`ifdef BRAM_EPP_WRAP_EN
  assign w_wr_block = 1'b0;
`else
  // A saturated address must not be overwritten repeatedly; block writes
  // until the host acknowledges the overflow.
  assign w_wr_block = r_ovf;
`endif

  // The BRAM is touched only in ACCESS, and never while the acquisition
  // state machine owns it.
  assign w_bram_go  = (r_state == c_st_access) && w_data_acc && !stmBusy;
  assign enBram     = w_bram_go && !(r_write && w_wr_block);
  assign ctrlWeBram = w_bram_go && r_write && !w_wr_block;
  assign busBramOut = ctrlWeBram ? busEppIn : 8'h00;

  // Address advances on the way into HOLD after a completed data access
  assign w_inc_en = r_auto_inc &&
                    (((r_state == c_st_access) && w_data_acc && r_write && !stmBusy) ||
                     (r_state == c_st_read_wait));

  assign eppWait     = (r_state == c_st_hold);
  assign busBramAddr = r_addr;
  assign busEppOut   = r_dout;
  assign ovfFlag     = r_ovf;

  // Next-state logic for the EPP handshake sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_fall) begin
          if ((busEppAddrIn[7:6] == c_sel_data) && stmBusy) begin
            w_state_nxt = c_st_wait_busy;
          end else begin
            w_state_nxt = c_st_access;
          end
        end
      end
      c_st_wait_busy: begin
        // Host giving up takes priority over a late BRAM release
        if (r_stb_s2) begin
          w_state_nxt = c_st_idle;
        end else if (!stmBusy) begin
          w_state_nxt = c_st_access;
        end
      end
      c_st_access: begin
        // Ownership can be taken back in the cycle we meant to use; defer
        if (w_data_acc && stmBusy) begin
          w_state_nxt = c_st_wait_busy;
        end else if (w_data_acc && !r_write) begin
          w_state_nxt = c_st_read_wait;
        end else begin
          w_state_nxt = c_st_hold;
        end
      end
      c_st_read_wait: begin
        w_state_nxt = c_st_hold;
      end
      c_st_hold: begin
        // The level check also covers a strobe released before HOLD was reached
        if (w_rise || r_stb_s2) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Register read multiplexer; the high address byte is zero-extended
  always_comb begin
    w_reg_rd = 8'h00;
    case (r_sel)
      c_sel_addrl: w_reg_rd = r_addr[7:0];
      c_sel_addrh: w_reg_rd = 8'(r_addr[ADDR_W-1:8]);
      c_sel_ctrl:  w_reg_rd = {r_ovf, stmBusy, 5'b0_0000, r_auto_inc};
      default:     w_reg_rd = 8'h00;
    endcase
  end

  // Access capture, register file, read-data register and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= c_sel_data;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_auto_inc <= 1'(AUTO_INC_RST);
      r_ovf      <= 1'b0;
      r_dout     <= 8'h00;
    end else begin
      // Latch the target and direction at the start of the cycle
      if ((r_state == c_st_idle) && w_fall) begin
        r_sel   <= busEppAddrIn[7:6];
        r_write <= ~ctrlWr;
      end

      if ((r_state == c_st_access) && !w_data_acc) begin
        if (r_write) begin
          case (r_sel)
            c_sel_addrl: r_addr[7:0] <= busEppIn;
            c_sel_addrh: r_addr[ADDR_W-1:8] <= busEppIn[ADDR_W-9:0];
            c_sel_ctrl: begin
              r_auto_inc <= busEppIn[0];
              if (busEppIn[1]) begin
                r_ovf <= 1'b0;
              end
              if (busEppIn[7]) begin
                r_addr <= '0;
              end
            end
            default: begin
            end
          endcase
        end else begin
          r_dout <= w_reg_rd;
        end
      end

      if (r_state == c_st_read_wait) begin
        r_dout <= busBramIn;
      end

      if (w_inc_en) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
`ifdef BRAM_EPP_WRAP_EN
          r_addr <= '0;
`endif
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_epp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_epp_ctrl
// Purpose  : Directed self-checking bench for bram_epp_ctrl with a behavioural
//            synchronous-read BRAM and EPP host tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_epp_ctrl;

  localparam int ADDR_W = 12;

  localparam logic [1:0] SEL_DATA  = 2'b00;
  localparam logic [1:0] SEL_ADDRL = 2'b01;
  localparam logic [1:0] SEL_ADDRH = 2'b10;
  localparam logic [1:0] SEL_CTRL  = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              stbData;
  logic              ctrlWr;
  logic [7:0]        busEppIn;
  logic [7:0]        busEppAddrIn;
  logic              stmBusy;
  logic [7:0]        busBramIn;
  logic [7:0]        busEppOut;
  logic              eppWait;
  logic [ADDR_W-1:0] busBramAddr;
  logic [7:0]        busBramOut;
  logic              ctrlWeBram;
  logic              enBram;
  logic              ovfFlag;

  int n_checks = 0;
  int n_fail   = 0;

  // BRAM model and monitors
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rdata = 8'h00;
  int         we_count  = 0;
  int         busy_viol = 0;

  assign busBramIn = rdata;

  always #5 clk = ~clk;

  bram_epp_ctrl #(
    .ADDR_W       (ADDR_W),
    .AUTO_INC_RST (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stbData      (stbData),
    .ctrlWr       (ctrlWr),
    .busEppIn     (busEppIn),
    .busEppAddrIn (busEppAddrIn),
    .stmBusy      (stmBusy),
    .busBramIn    (busBramIn),
    .busEppOut    (busEppOut),
    .eppWait      (eppWait),
    .busBramAddr  (busBramAddr),
    .busBramOut   (busBramOut),
    .ctrlWeBram   (ctrlWeBram),
    .enBram       (enBram),
    .ovfFlag      (ovfFlag)
  );

  always @(posedge clk) begin
    if (enBram) begin
      if (ctrlWeBram) mem[busBramAddr] <= busBramOut;
      rdata <= mem[busBramAddr];
    end
    if (ctrlWeBram) we_count <= we_count + 1;
    if (ctrlWeBram && stmBusy) busy_viol <= busy_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic epp_start(input logic [1:0] sel, input logic wr, input logic [7:0] din);
    @(negedge clk);
    busEppAddrIn = {sel, 6'h00};
    busEppIn     = din;
    ctrlWr       = ~wr;
    stbData      = 1'b0;
  endtask

  task automatic epp_wait_ack(output int lat);
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (eppWait) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic epp_end();
    int gone;
    stbData = 1'b1;
    gone = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!eppWait) begin
        gone = 1;
        break;
      end
    end
    if (gone == 0) check("release_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic epp_access(input logic [1:0] sel, input logic wr, input logic [7:0] din,
                            output logic [7:0] dout, output int lat);
    epp_start(sel, wr, din);
    epp_wait_ack(lat);
    dout = busEppOut;
    epp_end();
  endtask

  initial begin
    logic [7:0] d;
    int         lat;
    int         we_before;
    int         saw_wait;
    int         seen;

    rst          = 1'b1;
    stbData      = 1'b1;
    ctrlWr       = 1'b1;
    busEppIn     = 8'h00;
    busEppAddrIn = 8'h00;
    stmBusy      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_addr",    32'(busBramAddr), 32'h000);
    check("rst_wait",    32'(eppWait),     32'd0);
    check("rst_we",      32'(ctrlWeBram),  32'd0);
    check("rst_en",      32'(enBram),      32'd0);
    check("rst_dout",    32'(busEppOut),   32'h00);
    check("rst_ovf",     32'(ovfFlag),     32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    epp_access(SEL_CTRL, 1'b0, 8'h00, d, lat);
    check("status_after_rst", 32'(d), 32'h01);
    check("lat_reg_read",     32'(lat), 32'd4);

    // Overflow scenario at the top of the address space
    epp_access(SEL_ADDRL, 1'b1, 8'hFE, d, lat);
    check("lat_reg_write", 32'(lat), 32'd4);
    epp_access(SEL_ADDRH, 1'b1, 8'h0F, d, lat);
    check("addr_set_ffe", 32'(busBramAddr), 32'hFFE);
    epp_access(SEL_ADDRL, 1'b0, 8'h00, d, lat);
    check("read_addrl", 32'(d), 32'hFE);
    epp_access(SEL_ADDRH, 1'b0, 8'h00, d, lat);
    check("read_addrh", 32'(d), 32'h0F);
    we_before = we_count;
    epp_access(SEL_DATA, 1'b1, 8'hA1, d, lat);
    check("lat_data_write", 32'(lat), 32'd4);
    epp_access(SEL_DATA, 1'b1, 8'hA2, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'hA3, d, lat);
    check("mem_ffe", 32'(mem[12'hFFE]), 32'hA1);
    check("mem_fff", 32'(mem[12'hFFF]), 32'hA2);
    check("ovf_set", 32'(ovfFlag), 32'd1);
`ifdef BRAM_EPP_WRAP_EN
    check("mem_000_wrap", 32'(mem[12'h000]), 32'hA3);
    check("addr_after_wrap", 32'(busBramAddr), 32'h001);
    check("we_count_wrap", 32'(we_count - we_before), 32'd3);
`else
    check("addr_saturated", 32'(busBramAddr), 32'hFFF);
    check("we_count_sat", 32'(we_count - we_before), 32'd2);
`endif
    epp_access(SEL_CTRL, 1'b0, 8'h00, d, lat);
    check("status_ovf", 32'(d), 32'h81);
    // autoInc on, clear overflow, zero address
    epp_access(SEL_CTRL, 1'b1, 8'h83, d, lat);
    check("ovf_cleared", 32'(ovfFlag), 32'd0);
    check("addr_zeroed", 32'(busBramAddr), 32'h000);

    // Fill 0x010..0x012, rewind, read back
    epp_access(SEL_ADDRL, 1'b1, 8'h10, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'h11, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'h22, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'h33, d, lat);
    epp_access(SEL_ADDRL, 1'b1, 8'h10, d, lat);
    check("addr_rewind", 32'(busBramAddr), 32'h010);
    epp_access(SEL_DATA, 1'b0, 8'h00, d, lat);
    check("rd0_data", 32'(d), 32'h11);
    check("rd0_lat",  32'(lat), 32'd5);
    epp_access(SEL_DATA, 1'b0, 8'h00, d, lat);
    check("rd1_data", 32'(d), 32'h22);
    check("rd1_lat",  32'(lat), 32'd5);
    epp_access(SEL_DATA, 1'b0, 8'h00, d, lat);
    check("rd2_data", 32'(d), 32'h33);
    check("rd2_lat",  32'(lat), 32'd5);
    check("addr_after_reads", 32'(busBramAddr), 32'h013);

    // Write held off by stmBusy for 20 cycles
    epp_access(SEL_ADDRL, 1'b1, 8'h20, d, lat);
    stmBusy   = 1'b1;
    we_before = we_count;
    epp_start(SEL_DATA, 1'b1, 8'h5A);
    saw_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eppWait) saw_wait = 1;
    end
    check("busy_no_wait", 32'(saw_wait), 32'd0);
    check("busy_no_write", 32'(we_count - we_before), 32'd0);
    stmBusy = 1'b0;
    epp_wait_ack(lat);
    epp_end();
    check("busy_one_write", 32'(we_count - we_before), 32'd1);
    check("busy_mem_020", 32'(mem[12'h020]), 32'h5A);
    check("busy_addr_021", 32'(busBramAddr), 32'h021);

    // Host abandons the cycle while stmBusy is held
    stmBusy   = 1'b1;
    we_before = we_count;
    epp_start(SEL_DATA, 1'b1, 8'h77);
    repeat (6) @(negedge clk);
    stbData = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_wait", 32'(eppWait), 32'd0);
    check("abort_addr", 32'(busBramAddr), 32'h021);
    stmBusy = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_write", 32'(we_count - we_before), 32'd0);
    epp_access(SEL_CTRL, 1'b0, 8'h00, d, lat);
    check("abort_idle_status", 32'(d), 32'h01);
    check("abort_idle_lat", 32'(lat), 32'd4);

    // autoInc disabled: repeated writes land on the same address
    epp_access(SEL_CTRL, 1'b1, 8'h00, d, lat);
    epp_access(SEL_ADDRL, 1'b1, 8'h05, d, lat);
    epp_access(SEL_ADDRH, 1'b1, 8'h00, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'h3C, d, lat);
    epp_access(SEL_DATA, 1'b1, 8'hC3, d, lat);
    check("noinc_addr", 32'(busBramAddr), 32'h005);
    check("noinc_mem", 32'(mem[12'h005]), 32'hC3);
    epp_access(SEL_CTRL, 1'b0, 8'h00, d, lat);
    check("noinc_status", 32'(d), 32'h00);

    // Reset during the ACCESS cycle of a write
    epp_access(SEL_ADDRL, 1'b1, 8'hAB, d, lat);
    we_before = we_count;
    epp_start(SEL_DATA, 1'b1, 8'h99);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ctrlWeBram) begin
        seen = 1;
        break;
      end
    end
    check("rst_mid_seen_we", 32'(seen), 32'd1);
    rst     = 1'b1;
    stbData = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(ctrlWeBram), 32'd0);
    check("rst_mid_addr", 32'(busBramAddr), 32'h000);
    check("rst_mid_wait", 32'(eppWait), 32'd0);
    @(negedge clk);
    check("rst_mid_we_count", 32'(we_count - we_before), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    epp_access(SEL_CTRL, 1'b0, 8'h00, d, lat);
    check("rst_mid_autoinc", 32'(d), 32'h01);

    check("never_write_while_busy", 32'(busy_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
